mem_access_unit: RTL

Initiator side of the data-memory port in the MEM stage. Accepts one load or store per request from the EX/MEM register and drives `dmAddr`/`dmWriteData`/`dmRead`/`dmWrite` into the word-wide data memory. Byte and halfword loads are extracted and sign- or zero-extended; byte and halfword stores are done as a two-cycle read-modify-write. `stall` holds the pipeline while an access is in flight.

---
 rtl/mem_access_pkg.sv | 28 ++
 rtl/load_align.sv | 26 ++
 rtl/mem_access_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared size encodings, FSM states and alignment rule for the MEM-stage data port.
// Pure declarations, no timing or flow control of its own.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WR,
    RMW_RD,
    RMW_WR,
    FAULT
  } state_t;

  // The illegal size encoding is treated as a misalignment so it takes the fault path.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return addr_lo != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts a byte/half/word lane from a little-endian memory word and extends it.
// Purely combinational (zero latency); no flow control.
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{addr_lo, 3'b000} +: 8];
    half_v = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: data = {{24{sign_ext & byte_v[7]}}, byte_v};
      SIZE_HALF: data = {{16{sign_ext & half_v[15]}}, half_v};
      default:   data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory initiator: loads 2 edges, word stores 2, sub-word RMW stores 3, faults 2.
// stall is high while busy; reqValid is ignored outside IDLE so upstream must hold its request.
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  size,
  input  logic        signExt,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  input  logic [31:0] dmReadData,
  output logic [31:0] dmAddr,
  output logic [31:0] dmWriteData,
  output logic        dmRead,
  output logic        dmWrite,
  output logic [31:0] loadData,
  output logic        done,
  output logic        misaligned,
  output logic        stall
);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] load_q, load_d;
  logic        done_q, done_d;
  logic        mis_q, mis_d;
  logic        stall_q, stall_d;

  logic [31:0] align_data;
  logic [31:0] merged;

  load_align u_load_align (
    .word     (dmReadData),
    .addr_lo  (addr_q[1:0]),
    .size     (size_q),
    .sign_ext (sext_q),
    .data     (align_data)
  );

  // Only byte and half reach RMW_WR, so anything that is not a byte is a half here.
  always_comb begin
    merged = merge_q;
    if (size_q == SIZE_BYTE) merged[{addr_q[1:0], 3'b000} +: 8] = store_q[7:0];
    else                     merged[{addr_q[1], 4'b0000} +: 16] = store_q[15:0];
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    size_d  = size_q;
    sext_d  = sext_q;
    merge_d = merge_q;
    load_d  = load_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (reqValid) begin
          addr_d  = addr;
          store_d = storeData;
          size_d  = size;
          sext_d  = signExt;
          if ((memRead && memWrite) || isMisaligned(size, addr[1:0])) state_d = FAULT;
          else if (memRead)                                            state_d = LOAD;
          else if (memWrite)  state_d = (size == SIZE_WORD) ? WR : RMW_RD;
          else                                                         done_d  = 1'b1;
        end
      end
      LOAD: begin
        load_d  = align_data;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      WR: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      RMW_RD: begin
        merge_d = dmReadData;
        state_d = RMW_WR;
      end
      RMW_WR: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      FAULT: begin
        done_d  = 1'b1;
        mis_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    stall_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      merge_q <= '0;
      load_q  <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      merge_q <= merge_d;
      load_q  <= load_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      stall_q <= stall_d;
    end
  end

  assign dmAddr      = {2'b00, addr_q[31:2]};
  assign dmRead      = ~reset & ((state_q == LOAD) || (state_q == RMW_RD));
  assign dmWrite     = ~reset & ((state_q == WR) || (state_q == RMW_WR));
  assign dmWriteData = (state_q == RMW_WR) ? merged : ((state_q == WR) ? store_q : '0);
  assign loadData    = load_q;
  assign done        = done_q;
  assign misaligned  = mis_q;
  assign stall       = stall_q;

endmodule
